if_fetch_stage: RTL and testbench

- Instruction-fetch stage of the pipelined MIPS core. Owns the PC register and drives the instruction-memory request/acknowledge handshake.
- Applies stall and branch/jump redirects, and presents the fetched instruction plus PC+4 to the IF/ID pipeline register that sits directly downstream.
- Squashes wrong-path fetches by presenting a NOP (32'h0) bubble.

---
 rtl/if_pkg.sv | 18 +
 rtl/if_next_pc.sv | 34 +++
 rtl/if_fetch_stage.sv | 137 +++++++++++++
 tb/tb_if_fetch_stage.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/if_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package if_pkg;

   typedef enum logic [0:0] {
      S_REQ   = 1'b0,
      S_VALID = 1'b1
   } if_state_e;

   localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
   localparam logic [31:0] PC_INCR          = 32'd4;
   localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

   // Instruction addresses are word aligned; the low two bits are dropped.
   function automatic logic [31:0] word_align(input logic [31:0] addr);
      return addr & 32'hFFFF_FFFC;
   endfunction

endpackage

// File: rtl/if_next_pc.sv
// Next fetch address selection: a taken branch beats a jump, and the
// redirect target is always word aligned.
module if_next_pc
   import if_pkg::*;
(
   input  logic        pc_write_i,
   input  logic [31:0] pc_i,
   input  logic        branch_taken_i,
   input  logic [31:0] branch_target_i,
   input  logic        jump_i,
   input  logic [31:0] jump_target_i,
   output logic        redirect_o,
   output logic [31:0] target_o,
   output logic [31:0] seq_pc_o,
   output logic [31:0] next_pc_o
);

   // Target mux, redirect qualification and sequential increment.
   always_comb begin
      if (branch_taken_i) begin
         target_o = word_align(branch_target_i);
      end else begin
         target_o = word_align(jump_target_i);
      end
      redirect_o = pc_write_i & (branch_taken_i | jump_i);
      seq_pc_o   = pc_i + PC_INCR;
      if (redirect_o) begin
         next_pc_o = target_o;
      end else begin
         next_pc_o = seq_pc_o;
      end
   end

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: PC register, imem request/ack handshake,
// redirect handling and wrong-path squash toward IF/ID.
module if_fetch_stage
   import if_pkg::*;
#(
   parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
)(
   input  logic        clk,
   input  logic        Reset,
   input  logic        PCWrite,
   input  logic        BranchTaken,
   input  logic [31:0] BranchTarget,
   input  logic        Jump,
   input  logic [31:0] JumpTarget,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic [31:0] Instruction,
   output logic [31:0] PCPlus4,
   output logic        FetchStall
);

   if_state_e   state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] instr_q, instr_d;
   logic        redir_pend_q, redir_pend_d;
   logic [31:0] redir_pc_q, redir_pc_d;

   logic        redirect_s;
   logic [31:0] target_s;
   logic [31:0] seq_pc_s;
   logic [31:0] next_pc_s;
   logic        req_s;
   logic [31:0] addr_s;
   logic [31:0] instr_out_s;
   logic        stall_s;

   if_next_pc u_next_pc (
      .pc_write_i      (PCWrite),
      .pc_i            (pc_q),
      .branch_taken_i  (BranchTaken),
      .branch_target_i (BranchTarget),
      .jump_i          (Jump),
      .jump_target_i   (JumpTarget),
      .redirect_o      (redirect_s),
      .target_o        (target_s),
      .seq_pc_o        (seq_pc_s),
      .next_pc_o       (next_pc_s)
   );

   // Fetch FSM: next state and handshake outputs.
   always_comb begin
      state_d      = state_q;
      pc_d         = pc_q;
      instr_d      = instr_q;
      redir_pend_d = redir_pend_q;
      redir_pc_d   = redir_pc_q;
      req_s        = 1'b0;
      addr_s       = pc_q;
      instr_out_s  = NOP_INSTR;
      stall_s      = 1'b1;

      case (state_q)
         S_REQ: begin
            req_s = 1'b1;
            if (imem_ack) begin
               // A redirect seen this cycle is newer than any pending one.
               if (redirect_s) begin
                  pc_d         = target_s;
                  redir_pend_d = 1'b0;
               end else if (redir_pend_q) begin
                  pc_d         = redir_pc_q;
                  redir_pend_d = 1'b0;
               end else begin
                  instr_d = imem_rdata;
                  state_d = S_VALID;
               end
            end else if (redirect_s) begin
               redir_pend_d = 1'b1;
               redir_pc_d   = target_s;
            end else begin
               redir_pend_d = redir_pend_q;
            end
         end

         S_VALID: begin
            stall_s = 1'b0;
            addr_s  = next_pc_s;
            if (redirect_s) begin
               instr_out_s = NOP_INSTR;
            end else begin
               instr_out_s = instr_q;
            end
            if (PCWrite) begin
               req_s = 1'b1;
               pc_d  = next_pc_s;
               if (imem_ack) begin
                  instr_d = imem_rdata;
               end else begin
                  state_d = S_REQ;
               end
            end else begin
               req_s = 1'b0;
            end
         end

         default: begin
            state_d = S_REQ;
         end
      endcase
   end

   // State registers; imem_ack is ignored while Reset is high.
   always_ff @(posedge clk) begin
      if (Reset) begin
         state_q      <= S_REQ;
         pc_q         <= word_align(RESET_PC);
         instr_q      <= NOP_INSTR;
         redir_pend_q <= 1'b0;
         redir_pc_q   <= 32'h0000_0000;
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         instr_q      <= instr_d;
         redir_pend_q <= redir_pend_d;
         redir_pc_q   <= redir_pc_d;
      end
   end

   assign imem_req    = req_s & ~Reset;
   assign imem_addr   = word_align(addr_s);
   assign Instruction = instr_out_s;
   assign PCPlus4     = seq_pc_s;
   assign FetchStall  = stall_s;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed, table-driven bench for if_fetch_stage.
module tb_if_fetch_stage;

   logic        clk = 1'b0;
   logic        Reset;
   logic        PCWrite;
   logic        BranchTaken;
   logic [31:0] BranchTarget;
   logic        Jump;
   logic [31:0] JumpTarget;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic [31:0] Instruction;
   logic [31:0] PCPlus4;
   logic        FetchStall;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   if_fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
      .clk          (clk),
      .Reset        (Reset),
      .PCWrite      (PCWrite),
      .BranchTaken  (BranchTaken),
      .BranchTarget (BranchTarget),
      .Jump         (Jump),
      .JumpTarget   (JumpTarget),
      .imem_req     (imem_req),
      .imem_addr    (imem_addr),
      .imem_ack     (imem_ack),
      .imem_rdata   (imem_rdata),
      .Instruction  (Instruction),
      .PCPlus4      (PCPlus4),
      .FetchStall   (FetchStall)
   );

   typedef struct {
      logic        rst;
      logic        pw;
      logic        bt;
      logic [31:0] btgt;
      logic        jp;
      logic [31:0] jtgt;
      logic        ack;
      logic [31:0] rdata;
      logic        e_req;
      logic [31:0] e_addr;
      logic [31:0] e_instr;
      logic [31:0] e_pc4;
      logic        e_stall;
   } vec_t;

   localparam int NV = 39;
   vec_t v [NV];

   function automatic logic [31:0] tag(input logic [31:0] a);
      return 32'h1000_0000 | a;
   endfunction

   function automatic vec_t mk(input logic rst, input logic pw, input logic bt, input logic [31:0] btgt,
                               input logic jp, input logic [31:0] jtgt, input logic ack, input logic [31:0] rdata,
                               input logic e_req, input logic [31:0] e_addr, input logic [31:0] e_instr,
                               input logic [31:0] e_pc4, input logic e_stall);
      vec_t r;
      r.rst = rst; r.pw = pw; r.bt = bt; r.btgt = btgt; r.jp = jp; r.jtgt = jtgt;
      r.ack = ack; r.rdata = rdata; r.e_req = e_req; r.e_addr = e_addr;
      r.e_instr = e_instr; r.e_pc4 = e_pc4; r.e_stall = e_stall;
      return r;
   endfunction

   task automatic chk(input string name, input int row, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s row %0d: got %h expected %h", name, row, act, exp);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      //        rst   pw    bt    btgt          jp    jtgt          ack   rdata             req   addr          instr             pc4           stall
      v[0]  = mk(1'b1, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 32'h0,            1'b0, 32'h0,        32'h0,            32'h4,        1'b1);
      // zero-wait sequential stream
      v[1]  = mk(1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 32'h0,        1'b1, tag(32'h0),       1'b1, 32'h0,        32'h0,            32'h4,        1'b1);
      v[2]  = mk(1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 32'h0,        1'b1, tag(32'h4),       1'b1, 32'h4,        tag(32'h0),       32'h4,        1'b0);
      v[3]  = mk(1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 32'h0,        1'b1, tag(32'h8),       1'b1, 32'h8,        tag(32'h4),       32'h8,        1'b0);
      v[4]  = mk(1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 32'h0,        1'b1, tag(32'hC),       1'b1, 32'hC,        tag(32'h8),       32'hC,        1'b0);
      // PCWrite low holds everything
      v[5]  = mk(1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 32'h0,            1'b0, 32'h0,        tag(32'hC),       32'h10,       1'b0);
      v[6]  = mk(1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 32'h0,            1'b0, 32'h0,        tag(32'hC),       32'h10,       1'b0);
      v[7]  = mk(1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 32'h0,            1'b0, 32'h0,        tag(32'hC),       32'h10,       1'b0);
      v[8]  = mk(1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 32'h0,            1'b0, 32'h0,        tag(32'hC),       32'h10,       1'b0);
      v[9]  = mk(1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 32'h0,        1'b1, tag(32'h10),      1'b1, 32'h10,       tag(32'hC),       32'h10,       1'b0);
      // branch with unaligned target, squash
      v[10] = mk(1'b0, 1'b1, 1'b1, 32'h103,      1'b0, 32'h0,        1'b0, 32'h0,            1'b1, 32'h100,      32'h0,            32'h14,       1'b0);
      v[11] = mk(1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 32'h0,        1'b1, tag(32'h100),     1'b1, 32'h100,      32'h0,            32'h104,      1'b1);
      // branch and jump together: branch wins
      v[12] = mk(1'b0, 1'b1, 1'b1, 32'h200,      1'b1, 32'h300,      1'b1, tag(32'h200),     1'b1, 32'h200,      32'h0,            32'h104,      1'b0);
      v[13] = mk(1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 32'h0,            1'b0, 32'h0,        tag(32'h200),     32'h204,      1'b0);
      // jump only, then 3 wait cycles
      v[14] = mk(1'b0, 1'b1, 1'b0, 32'h0,        1'b1, 32'h402,      1'b0, 32'h0,            1'b1, 32'h400,      32'h0,            32'h204,      1'b0);
      v[15] = mk(1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 32'h0,            1'b1, 32'h400,      32'h0,            32'h404,      1'b1);
      v[16] = mk(1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 32'h0,            1'b1, 32'h400,      32'h0,            32'h404,      1'b1);
      v[17] = mk(1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 32'h0,            1'b1, 32'h400,      32'h0,            32'h404,      1'b1);
      v[18] = mk(1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 32'h0,        1'b1, tag(32'h400),     1'b1, 32'h400,      32'h0,            32'h404,      1'b1);
      v[19] = mk(1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 32'h0,            1'b0, 32'h0,        tag(32'h400),     32'h404,      1'b0);
      // redirect to 0x40 while waiting on addr 8
      v[20] = mk(1'b0, 1'b1, 1'b0, 32'h0,        1'b1, 32'h8,        1'b0, 32'h0,            1'b1, 32'h8,        32'h0,            32'h404,      1'b0);
      v[21] = mk(1'b0, 1'b1, 1'b1, 32'h40,       1'b0, 32'h0,        1'b0, 32'h0,            1'b1, 32'h8,        32'h0,            32'hC,        1'b1);
      v[22] = mk(1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 32'h0,            1'b1, 32'h8,        32'h0,            32'hC,        1'b1);
      v[23] = mk(1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 32'h0,        1'b1, tag(32'h8),       1'b1, 32'h8,        32'h0,            32'hC,        1'b1);
      v[24] = mk(1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 32'h0,        1'b1, tag(32'h40),      1'b1, 32'h40,       32'h0,            32'h44,       1'b1);
      v[25] = mk(1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 32'h0,            1'b0, 32'h0,        tag(32'h40),      32'h44,       1'b0);
      // pending redirect overridden by a redirect in the ack cycle
      v[26] = mk(1'b0, 1'b1, 1'b0, 32'h0,        1'b1, 32'h80,       1'b0, 32'h0,            1'b1, 32'h80,       32'h0,            32'h44,       1'b0);
      v[27] = mk(1'b0, 1'b1, 1'b1, 32'h90,       1'b0, 32'h0,        1'b0, 32'h0,            1'b1, 32'h80,       32'h0,            32'h84,       1'b1);
      v[28] = mk(1'b0, 1'b1, 1'b0, 32'h0,        1'b1, 32'hA0,       1'b1, tag(32'h80),      1'b1, 32'h80,       32'h0,            32'h84,       1'b1);
      v[29] = mk(1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 32'h0,        1'b1, tag(32'hA0),      1'b1, 32'hA0,       32'h0,            32'hA4,       1'b1);
      v[30] = mk(1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 32'h0,            1'b0, 32'h0,        tag(32'hA0),      32'hA4,       1'b0);
      // reset while waiting, with ack in the reset cycle
      v[31] = mk(1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 32'h0,            1'b1, 32'hA4,       tag(32'hA0),      32'hA4,       1'b0);
      v[32] = mk(1'b1, 1'b1, 1'b0, 32'h0,        1'b0, 32'h0,        1'b1, tag(32'hA4),      1'b0, 32'h0,        32'h0,            32'hA8,       1'b1);
      v[33] = mk(1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 32'h0,            1'b1, 32'h0,        32'h0,            32'h4,        1'b1);
      v[34] = mk(1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 32'h0,        1'b1, tag(32'h0),       1'b1, 32'h0,        32'h0,            32'h4,        1'b1);
      v[35] = mk(1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 32'h0,            1'b0, 32'h0,        tag(32'h0),       32'h4,        1'b0);
      // address wrap at the top of memory
      v[36] = mk(1'b0, 1'b1, 1'b0, 32'h0,        1'b1, 32'hFFFF_FFFC, 1'b1, 32'hDEAD_BEEF,    1'b1, 32'hFFFF_FFFC, 32'h0,           32'h4,        1'b0);
      v[37] = mk(1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 32'h0,        1'b1, tag(32'h0),       1'b1, 32'h0,        32'hDEAD_BEEF,    32'h0,        1'b0);
      v[38] = mk(1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 32'h0,            1'b0, 32'h0,        tag(32'h0),       32'h4,        1'b0);

      Reset = 1'b1; PCWrite = 1'b0; BranchTaken = 1'b0; BranchTarget = 32'h0;
      Jump = 1'b0; JumpTarget = 32'h0; imem_ack = 1'b0; imem_rdata = 32'h0;
      repeat (2) @(posedge clk);

      for (int i = 0; i < NV; i++) begin
         @(negedge clk);
         Reset = v[i].rst; PCWrite = v[i].pw; BranchTaken = v[i].bt; BranchTarget = v[i].btgt;
         Jump = v[i].jp; JumpTarget = v[i].jtgt; imem_ack = v[i].ack; imem_rdata = v[i].rdata;
         #1;
         chk("imem_req", i, {31'h0, imem_req}, {31'h0, v[i].e_req});
         if (v[i].e_req) begin
            chk("imem_addr", i, imem_addr, v[i].e_addr);
         end
         chk("Instruction", i, Instruction, v[i].e_instr);
         chk("PCPlus4", i, PCPlus4, v[i].e_pc4);
         chk("FetchStall", i, {31'h0, FetchStall}, {31'h0, v[i].e_stall});
      end

      // Hand sequence: 4-wait fetch after reset, then bounded wait for valid.
      @(negedge clk);
      Reset = 1'b1; PCWrite = 1'b1; BranchTaken = 1'b0; Jump = 1'b0; imem_ack = 1'b0;
      @(negedge clk);
      Reset = 1'b0;
      for (int k = 0; k < 4; k++) begin
         #1;
         chk("ws_addr_held", 100 + k, imem_addr, 32'h0);
         chk("ws_stall", 100 + k, {31'h0, FetchStall}, 32'h1);
         chk("ws_instr_nop", 100 + k, Instruction, 32'h0);
         @(negedge clk);
      end
      imem_ack = 1'b1; imem_rdata = 32'h0BAD_F00D;
      @(negedge clk);
      imem_ack = 1'b0; PCWrite = 1'b0;
      n = 0;
      while (FetchStall !== 1'b0 && n < 8) begin
         @(negedge clk);
         n++;
      end
      #1;
      chk("ws_timeout", 200, {31'h0, (n < 8)}, 32'h1);
      chk("ws_instr", 201, Instruction, 32'h0BAD_F00D);
      chk("ws_pc4", 202, PCPlus4, 32'h4);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
